// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants for the Y86-64 instruction-memory boot loader: loader state
// encodings, frame header size and default memory/length-field sizes.
// No ports; imported by imem_loader and ld_checksum.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

   // Loader FSM states, 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHK    = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } loader_state_t;

   // Number of header bytes (little-endian length) preceding the payload.
   localparam int HDR_BYTES         = 2;
   // Default instruction memory capacity and length-field width.
   localparam int MEM_BYTES_DEFAULT = 1024;
   localparam int LEN_W_DEFAULT     = 16;

   // True in the states that consume frame bytes.
   function automatic logic state_accepts(input loader_state_t s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_loader_ld_checksum.sv
// -----------------------------------------------------------------------------
// ld_checksum
// 8-bit XOR accumulator for the payload checksum.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (sum -> 0)
//   clr  in   clear the sum to 0 (takes priority over en)
//   en   in   fold din into the sum this cycle
//   din  in   8-bit data to accumulate
//   sum  out  current 8-bit XOR of all enabled bytes since the last clear
// -----------------------------------------------------------------------------
module ld_checksum
   import imem_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   logic [7:0] r_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum <= 8'h00;
      end else if (clr) begin
         r_sum <= 8'h00;
      end else if (en) begin
         r_sum <= r_sum ^ din;
      end
   end

   assign sum = r_sum;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Byte-serial boot loader for the Y86-64 fetch-stage instruction memory.
// Accepts a frame LEN_LO, LEN_HI, <length> payload bytes, XOR checksum byte,
// writes the payload to addresses 0..length-1 and keeps the pipeline held
// until the image has been loaded and verified.
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are
// both 1. in_ready depends only on the loader state, never on in_valid, and a
// byte offered while in_ready=0 is left untouched for a later cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         1-cycle pulse, begins a load from IDLE/DONE/ERR
//   in_byte/valid frame byte stream input; in_ready is the accept output
//   imem_wEn/addr/wdata  registered memory write port (1-cycle after transfer)
//   cpu_hold      pipeline hold, low only in DONE
//   load_done     level, image loaded and checksum matched
//   load_err      level, length overflow or checksum mismatch
//   byte_count    payload bytes accepted in the current load
//   dbg_state     current FSM state, for observation
// -----------------------------------------------------------------------------
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int LEN_W     = LEN_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             imem_wEn,
   output logic [63:0]      imem_addr,
   output logic [7:0]       imem_wdata,
   output logic             cpu_hold,
   output logic             load_done,
   output logic             load_err,
   output logic [LEN_W-1:0] byte_count,
   output loader_state_t    dbg_state
);

   loader_state_t    r_state;
   loader_state_t    w_next_state;
   logic [LEN_W-1:0] r_length;
   logic [LEN_W-1:0] r_byte_count;
   logic             r_wen;
   logic [63:0]      r_waddr;
   logic [7:0]       r_wdata;

   logic             w_xfer;
   logic             w_data_xfer;
   logic             w_clear;
   logic [7:0]       w_sum;
   logic [LEN_W-1:0] w_full_len;
   logic [LEN_W-1:0] w_count_inc;

   assign w_xfer      = in_valid & in_ready;
   assign w_data_xfer = w_xfer & (r_state == ST_DATA);
   // Header length as it will be once the high byte lands this cycle.
   assign w_full_len  = LEN_W'({in_byte, r_length[7:0]});
   assign w_count_inc = r_byte_count + LEN_W'(1);

   ld_checksum u_checksum (
      .clk (clk),
      .rst (rst),
      .clr (w_clear),
      .en  (w_data_xfer),
      .din (in_byte),
      .sum (w_sum)
   );

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               w_next_state = ST_LEN_LO;
               w_clear      = 1'b1;
            end
         end
         ST_LEN_LO: begin
            if (w_xfer) w_next_state = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (w_xfer) begin
               if (w_full_len > LEN_W'(MEM_BYTES)) w_next_state = ST_ERR;
               else if (w_full_len == '0)          w_next_state = ST_CHK;
               else                                w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_xfer && (w_count_inc == r_length)) w_next_state = ST_CHK;
         end
         ST_CHK: begin
            if (w_xfer) w_next_state = (in_byte == w_sum) ? ST_DONE : ST_ERR;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      in_ready  = state_accepts(r_state);
      cpu_hold  = (r_state != ST_DONE);
      load_done = (r_state == ST_DONE);
      load_err  = (r_state == ST_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_length     <= '0;
         r_byte_count <= '0;
         r_wen        <= 1'b0;
         r_waddr      <= 64'd0;
         r_wdata      <= 8'h00;
      end else begin
         r_state <= w_next_state;
         // Write strobe is a pure one-cycle echo of a payload transfer, so
         // back-to-back transfers give back-to-back writes.
         r_wen   <= w_data_xfer;
         if (w_clear) begin
            r_length     <= '0;
            r_byte_count <= '0;
         end
         if (w_xfer && (r_state == ST_LEN_LO)) r_length[7:0] <= in_byte;
         if (w_xfer && (r_state == ST_LEN_HI)) r_length      <= w_full_len;
         if (w_data_xfer) begin
            r_byte_count <= w_count_inc;
            r_waddr      <= 64'(r_byte_count);
            r_wdata      <= in_byte;
         end
      end
   end

   assign imem_wEn   = r_wen;
   assign imem_addr  = r_waddr;
   assign imem_wdata = r_wdata;
   assign byte_count = r_byte_count;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: scenario tasks drive frames, expected
// memory writes (cycle, address, data) are queued as payload bytes transfer
// and compared against the writes observed on the memory port.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    in_byte = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          imem_wEn;
   logic [63:0]   imem_addr;
   logic [7:0]    imem_wdata;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;
   logic [15:0]   byte_count;
   loader_state_t dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // {cycle[15:0], addr[15:0], data[7:0]}
   logic [39:0] exp_q[$];
   logic [39:0] got_q[$];

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_byte    (in_byte),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_wEn   (imem_wEn),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .byte_count (byte_count),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: record every memory write with the cycle it appeared in.
   always @(negedge clk) begin
      if (imem_wEn) got_q.push_back({cyc[15:0], imem_addr[15:0], imem_wdata});
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got running, want finished");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send_byte(input logic [7:0] b, input bit is_payload, input int idx);
      int guard;
      guard    = 0;
      in_byte  = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready got 0, want 1 (byte %02h)", b);
         in_valid = 1'b0;
         return;
      end
      // Transfer happens at the next posedge; the write is visible in the cycle after it.
      if (is_payload) exp_q.push_back({16'(cyc + 1), 16'(idx), b});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] fr[$], input bit gap);
      int len;
      len = int'({fr[1], fr[0]});
      for (int i = 0; i < fr.size(); i++) begin
         send_byte(fr[i], (i >= 2) && (i < 2 + len) && (len <= 1024), i - 2);
         if (gap) @(negedge clk);
      end
   endtask

   // Compare all queued expected writes against observed writes.
   task automatic drain_writes(input string name);
      logic [39:0] e;
      logic [39:0] g;
      repeat (2) @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (got_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_missing_write: got none, want cyc=%0d addr=%0d data=%02h",
                     name, e[39:24], e[23:8], e[7:0]);
         end else begin
            g = got_q.pop_front();
            if (g !== e) begin
               n_err++;
               $display("FAIL %s_write: got cyc=%0d addr=%0d data=%02h, want cyc=%0d addr=%0d data=%02h",
                        name, g[39:24], g[23:8], g[7:0], e[39:24], e[23:8], e[7:0]);
            end
         end
      end
      n_vec++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_extra_writes: got %0d unexpected, want 0", name, got_q.size());
         got_q.delete();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
      n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_vec++; if (imem_wEn !== 1'b0)   begin n_err++; $display("FAIL reset_wen: got %b want 0", imem_wEn); end
      n_vec++; if (imem_addr !== 64'd0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
      n_vec++; if (imem_wdata !== 8'h0) begin n_err++; $display("FAIL reset_wdata: got %02h want 00", imem_wdata); end
      n_vec++; if (cpu_hold !== 1'b1)   begin n_err++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
      n_vec++; if (load_done !== 1'b0 || load_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got done=%b err=%b want 0 0", load_done, load_err); end
      n_vec++; if (byte_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", byte_count); end
      got_q.delete();
   endtask

   task automatic test_bad_checksum();
      pulse_start();
      send_frame('{8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'h00}, 1'b0);
      n_vec++; if (load_err !== 1'b1 || load_done !== 1'b0) begin n_err++; $display("FAIL badchk_flags: got err=%b done=%b want 1 0", load_err, load_done); end
      n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL badchk_hold: got %b want 1", cpu_hold); end
      n_vec++; if (byte_count !== 16'd3) begin n_err++; $display("FAIL badchk_count: got %0d want 3", byte_count); end
      drain_writes("badchk");
   endtask

   task automatic test_back_to_back();
      pulse_start();
      send_frame('{8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'hC8}, 1'b0);
      n_vec++; if (load_done !== 1'b1 || load_err !== 1'b0) begin n_err++; $display("FAIL b2b_flags: got done=%b err=%b want 1 0", load_done, load_err); end
      n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL b2b_hold: got %b want 0", cpu_hold); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
      drain_writes("b2b");
   endtask

   task automatic test_zero_len();
      pulse_start();
      send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
      n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", load_done); end
      n_vec++; if (byte_count !== 16'd0) begin n_err++; $display("FAIL zero_count: got %0d want 0", byte_count); end
      drain_writes("zero");
   endtask

   task automatic test_overflow();
      pulse_start();
      send_frame('{8'h01, 8'h04}, 1'b0);
      n_vec++; if (dbg_state !== ST_ERR || load_err !== 1'b1) begin n_err++; $display("FAIL ovf_state: got state=%0d err=%b want %0d 1", dbg_state, load_err, ST_ERR); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_in_ready: got %b want 0", in_ready); end
      drain_writes("ovf");
   endtask

   task automatic test_max_len();
      logic [7:0] fr[$];
      logic [7:0] b;
      logic [7:0] x;
      x = 8'h00;
      fr.push_back(8'h00);
      fr.push_back(8'h04);
      for (int i = 0; i < 1024; i++) begin
         b = 8'($urandom_range(0, 255));
         x ^= b;
         fr.push_back(b);
      end
      fr.push_back(x);
      pulse_start();
      send_frame(fr, 1'b0);
      n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL maxlen_done: got %b want 1", load_done); end
      n_vec++; if (byte_count !== 16'd1024) begin n_err++; $display("FAIL maxlen_count: got %0d want 1024", byte_count); end
      drain_writes("maxlen");
   endtask

   task automatic test_gap_and_reset();
      pulse_start();
      send_frame('{8'h02, 8'h00, 8'hAA}, 1'b1);
      n_vec++; if (dbg_state !== ST_DATA || byte_count !== 16'd1) begin n_err++; $display("FAIL gap_mid: got state=%0d count=%0d want %0d 1", dbg_state, byte_count, ST_DATA); end
      // Reset while a payload byte is being offered: it must not be consumed.
      in_byte  = 8'hBB;
      in_valid = 1'b1;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (dbg_state !== ST_IDLE || in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_state: got state=%0d rdy=%b want %0d 0", dbg_state, in_ready, ST_IDLE); end
      n_vec++; if (imem_wEn !== 1'b0 || byte_count !== 16'd0 || imem_addr !== 64'd0) begin n_err++; $display("FAIL rst_mid_outputs: got wen=%b count=%0d addr=%0h want 0 0 0", imem_wEn, byte_count, imem_addr); end
      n_vec++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags: got hold=%b done=%b err=%b want 1 0 0", cpu_hold, load_done, load_err); end
      // Valid bytes in IDLE are ignored.
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL idle_ignore: got state=%0d want %0d", dbg_state, ST_IDLE); end
      drain_writes("gaprst");
   endtask

   task automatic test_reload();
      pulse_start();
      send_frame('{8'h03, 8'h00, 8'h30, 8'hF2, 8'h0A, 8'hC8}, 1'b0);
      drain_writes("preload");
      n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL reload_pre_hold: got %b want 0", cpu_hold); end
      pulse_start();
      n_vec++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin n_err++; $display("FAIL reload_hold: got hold=%b done=%b want 1 0", cpu_hold, load_done); end
      n_vec++; if (byte_count !== 16'd0 || dbg_state !== ST_LEN_LO) begin n_err++; $display("FAIL reload_clear: got count=%0d state=%0d want 0 %0d", byte_count, dbg_state, ST_LEN_LO); end
      send_frame('{8'h01, 8'h00, 8'h55, 8'h55}, 1'b0);
      n_vec++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin n_err++; $display("FAIL reload_done: got done=%b hold=%b want 1 0", load_done, cpu_hold); end
      drain_writes("reload");
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_bad_checksum();
      test_back_to_back();
      test_zero_len();
      test_overflow();
      test_max_len();
      test_gap_and_reset();
      test_reload();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
